rr_arb: RTL and testbench

RR_ARB -- requirements
Module: rr_arb

---
 rtl/rr_arb.sv | 140 ++++++++++++++
 tb/tb_rr_arb.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/rr_arb.sv
// ----------------------------------------------------------------------------
// rr_arb -- registered round-robin arbiter with optional grant lock.
//
// A priority pointer marks the requester with the highest priority. The
// search descends from the pointer and wraps modulo NUM_REQ. After each
// new grant the pointer moves to (winner - 1), so the winner becomes the
// lowest-priority requester on the next arbitration.
//
// Parameters:
//   NUM_REQ : number of requesters (power of two, 2..32)
//   HOLD    : 1 = keep the grant while the holder still requests,
//             0 = re-arbitrate on every enabled cycle
//
// Ports:
//   clock     : single clock, rising-edge active
//   reset     : asynchronous active-high reset
//   en        : arbitration enable; low forces the grant off next cycle
//   req       : request vector, bit i belongs to requester i
//   gnt       : registered one-hot grant (or all zeros)
//   gnt_idx   : binary index of the granted requester (held while idle)
//   gnt_valid : high when gnt is nonzero
// ----------------------------------------------------------------------------
module rr_arb #(
    parameter int NUM_REQ = 8,
    parameter bit HOLD    = 1'b1,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_valid
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state_reg;
    logic [NUM_REQ-1:0] gnt_reg;
    logic [IDX_W-1:0]   gnt_idx_reg;
    logic               gnt_valid_reg;
    logic [IDX_W-1:0]   ptr_reg;

    // rot[k] is the request of the requester k steps below the pointer, so
    // the lowest set bit of rot is the first hit in the descending search.
    logic [NUM_REQ-1:0] rot;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi = gi + 1) begin : g_rot
            logic [IDX_W-1:0] src;
            // Unsigned subtraction wraps naturally modulo NUM_REQ.
            assign src     = ptr_reg - IDX_W'(gi);
            assign rot[gi] = req[src];
        end
    endgenerate

    logic               found_next;
    logic [IDX_W-1:0]   offset_next;
    logic [IDX_W-1:0]   win_idx_next;
    logic [NUM_REQ-1:0] win_onehot_next;

    always_comb begin
        found_next  = 1'b0;
        offset_next = '0;
        // Scan from the far end so the smallest set offset wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found_next  = 1'b1;
                offset_next = IDX_W'(k);
            end
        end
        win_idx_next    = ptr_reg - offset_next;
        win_onehot_next = NUM_REQ'(1) << win_idx_next;
    end

    // Request of the current holder, used by the grant-lock mode.
    logic holder_req;
    assign holder_req = req[gnt_idx_reg];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            gnt_reg       <= '0;
            gnt_idx_reg   <= '0;
            gnt_valid_reg <= 1'b0;
            ptr_reg       <= IDX_W'(NUM_REQ - 1);
        end else begin
            case (state_reg)
                IDLE: begin
                    if (en && found_next) begin
                        state_reg     <= BUSY;
                        gnt_reg       <= win_onehot_next;
                        gnt_idx_reg   <= win_idx_next;
                        gnt_valid_reg <= 1'b1;
                        ptr_reg       <= win_idx_next - 1'b1;
                    end else begin
                        gnt_reg       <= '0;
                        gnt_valid_reg <= 1'b0;
                    end
                end
                BUSY: begin
                    if (!en) begin
                        // Drop the grant; pointer and index are retained.
                        state_reg     <= IDLE;
                        gnt_reg       <= '0;
                        gnt_valid_reg <= 1'b0;
                    end else if (HOLD && holder_req) begin
                        // Grant lock: nothing changes while the holder asks.
                        state_reg <= BUSY;
                    end else if (found_next) begin
                        state_reg     <= BUSY;
                        gnt_reg       <= win_onehot_next;
                        gnt_idx_reg   <= win_idx_next;
                        gnt_valid_reg <= 1'b1;
                        ptr_reg       <= win_idx_next - 1'b1;
                    end else begin
                        state_reg     <= IDLE;
                        gnt_reg       <= '0;
                        gnt_valid_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    gnt_reg       <= '0;
                    gnt_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign gnt       = gnt_reg;
    assign gnt_idx   = gnt_idx_reg;
    assign gnt_valid = gnt_valid_reg;

endmodule

// File: tb/tb_rr_arb.sv
// ----------------------------------------------------------------------------
// tb_rr_arb -- scoreboard bench for rr_arb with NUM_REQ=4.
//
// Two instances share clock, reset, en and req: dut0 re-arbitrates every
// cycle (HOLD=0), dut1 locks the grant (HOLD=1). Each directed step pushes
// the hand-computed expected outputs of both instances into a queue; a
// monitor pops one entry after every rising edge that has one pending.
// ----------------------------------------------------------------------------
module tb_rr_arb;

    logic       clock;
    logic       reset;
    logic       en;
    logic [3:0] req;
    logic [3:0] gnt0, gnt1;
    logic [1:0] gnt_idx0, gnt_idx1;
    logic       gnt_valid0, gnt_valid1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         step;
        logic [3:0] r;
        logic       e;
        logic [3:0] g0;
        int         i0;
        logic [3:0] g1;
        int         i1;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   step_no = 0;

    rr_arb #(.NUM_REQ(4), .HOLD(1'b0)) dut0 (
        .clock     (clock),
        .reset     (reset),
        .en        (en),
        .req       (req),
        .gnt       (gnt0),
        .gnt_idx   (gnt_idx0),
        .gnt_valid (gnt_valid0)
    );

    rr_arb #(.NUM_REQ(4), .HOLD(1'b1)) dut1 (
        .clock     (clock),
        .reset     (reset),
        .en        (en),
        .req       (req),
        .gnt       (gnt1),
        .gnt_idx   (gnt_idx1),
        .gnt_valid (gnt_valid1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called at a falling edge: drive inputs, queue expectations, and return
    // at the next falling edge (one rising edge in between).
    task automatic step(input logic [3:0] r, input logic e,
                        input logic [3:0] g0, input int i0,
                        input logic [3:0] g1, input int i1);
        exp_t x;
        step_no++;
        req = r;
        en  = e;
        x.step = step_no; x.r = r; x.e = e;
        x.g0 = g0; x.i0 = i0; x.g1 = g1; x.i1 = i1;
        exp_q.push_back(x);
        @(negedge clock);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_gnt0"},   int'(gnt0), 0);
        chk({tag, "_idx0"},   int'(gnt_idx0), 0);
        chk({tag, "_valid0"}, int'(gnt_valid0), 0);
        chk({tag, "_gnt1"},   int'(gnt1), 0);
        chk({tag, "_idx1"},   int'(gnt_idx1), 0);
        chk({tag, "_valid1"}, int'(gnt_valid1), 0);
    endtask

    // Monitor: compare after every rising edge that has an expectation.
    always @(posedge clock) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            $display("step %0d req=%b en=%b | h0 gnt=%b idx=%0d vld=%b | h1 gnt=%b idx=%0d vld=%b",
                     mon_e.step, mon_e.r, mon_e.e, gnt0, gnt_idx0, gnt_valid0,
                     gnt1, gnt_idx1, gnt_valid1);
            chk($sformatf("s%0d_gnt0", mon_e.step),   int'(gnt0), int'(mon_e.g0));
            chk($sformatf("s%0d_idx0", mon_e.step),   int'(gnt_idx0), mon_e.i0);
            chk($sformatf("s%0d_valid0", mon_e.step), int'(gnt_valid0), (mon_e.g0 != 4'b0) ? 1 : 0);
            chk($sformatf("s%0d_gnt1", mon_e.step),   int'(gnt1), int'(mon_e.g1));
            chk($sformatf("s%0d_idx1", mon_e.step),   int'(gnt_idx1), mon_e.i1);
            chk($sformatf("s%0d_valid1", mon_e.step), int'(gnt_valid1), (mon_e.g1 != 4'b0) ? 1 : 0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        en    = 1'b0;
        req   = 4'b0000;
        #1;
        chk_reset_state("reset");
        @(negedge clock);
        reset = 1'b0;

        // Full request load: h0 rotates 3,2,1,0,3; h1 locks on 3.
        step(4'b1111, 1'b1, 4'b1000, 3, 4'b1000, 3);
        step(4'b1111, 1'b1, 4'b0100, 2, 4'b1000, 3);
        step(4'b1111, 1'b1, 4'b0010, 1, 4'b1000, 3);
        step(4'b1111, 1'b1, 4'b0001, 0, 4'b1000, 3);
        step(4'b1111, 1'b1, 4'b1000, 3, 4'b1000, 3);
        // Holder 3 drops: both pick 2.
        step(4'b0111, 1'b1, 4'b0100, 2, 4'b0100, 2);
        // Grant 0, pointer wraps to 3; then 1001 wins 3 on h0, h1 holds 0.
        step(4'b0001, 1'b1, 4'b0001, 0, 4'b0001, 0);
        step(4'b1001, 1'b1, 4'b1000, 3, 4'b0001, 0);
        // Enable low: grant off, index held; resumes from retained pointer.
        step(4'b0110, 1'b0, 4'b0000, 3, 4'b0000, 0);
        step(4'b0110, 1'b0, 4'b0000, 3, 4'b0000, 0);
        step(4'b0110, 1'b1, 4'b0100, 2, 4'b0100, 2);
        // No requests: idle, index held. Single requester granted each cycle.
        step(4'b0000, 1'b1, 4'b0000, 2, 4'b0000, 2);
        step(4'b0000, 1'b1, 4'b0000, 2, 4'b0000, 2);
        step(4'b0010, 1'b1, 4'b0010, 1, 4'b0010, 1);
        step(4'b0010, 1'b1, 4'b0010, 1, 4'b0010, 1);
        step(4'b1010, 1'b1, 4'b1000, 3, 4'b0010, 1);
        step(4'b0100, 1'b1, 4'b0100, 2, 4'b0100, 2);

        // Asynchronous reset mid-cycle while both grant 0100.
        #2;
        reset = 1'b1;
        req   = 4'b0000;
        en    = 1'b0;
        #1;
        chk_reset_state("async_reset");
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        // Fresh pointer = 3: 0101 picks 2 (highest index first).
        step(4'b0101, 1'b1, 4'b0100, 2, 4'b0100, 2);

        // Second reset, then 1111 x3 and 0111.
        reset = 1'b1;
        en    = 1'b0;
        req   = 4'b0000;
        #1;
        chk_reset_state("reset2");
        @(negedge clock);
        reset = 1'b0;
        step(4'b1111, 1'b1, 4'b1000, 3, 4'b1000, 3);
        step(4'b1111, 1'b1, 4'b0100, 2, 4'b1000, 3);
        step(4'b1111, 1'b1, 4'b0010, 1, 4'b1000, 3);
        step(4'b0111, 1'b1, 4'b0001, 0, 4'b0100, 2);
        step(4'b1111, 1'b0, 4'b0000, 0, 4'b0000, 2);

        @(posedge clock);
        #2;
        chk("queue_drain", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
